sys_ctrl_regs: RTL and testbench

SYS_CTRL_REGS -- requirements
Module: sys_ctrl_regs

---
 rtl/sys_ctrl_regs.sv | 199 +++++++++++++++++++
 tb/tb_sys_ctrl_regs.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_regs.sv
// System control register block: ID/CTRL registers, PLL serial configuration
// shifter, and per-channel frequency measurement over a fixed clk window.
module sys_ctrl_regs #(
    parameter logic [31:0] ID_VAL      = 32'h00800001,
    parameter int unsigned CFG_BITS    = 26,
    parameter int unsigned SCLK_DIV    = 4,
    parameter int unsigned NUM_MEAS    = 2,
    parameter int unsigned FREQ_WINDOW = 62500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reg_select,
    input  logic                reg_wr,
    input  logic [3:0]          reg_addr,
    input  logic [31:0]         reg_wdata,
    output logic [31:0]         reg_rdata,
    output logic                pll_nreset,
    output logic                pll_bypass,
    input  logic                pll_locked,
    output logic                pll_sclk,
    output logic                pll_sdi,
    input  logic                pll_sdo,
    output logic                pclk_reset_req,
    output logic                led,
    input  logic [NUM_MEAS-1:0] meas_in
);

    localparam int unsigned BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int unsigned DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned WW = $clog2(FREQ_WINDOW);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

    logic ctrl_wr, cfg_wr;
    logic pclk_req_q, nreset_q, bypass_q, led_q;
    logic locked_s1_q, locked_s2_q;

    state_e              state_q;
    logic                busy_q, done_q, sclk_q, sdi_q;
    logic [CFG_BITS-1:0] shift_q, cap_q, cap_d;
    logic [BW-1:0]       bit_q;
    logic [DW-1:0]       div_q;
    logic                div_last, bit_last;

    logic [NUM_MEAS-1:0] meas_s1_q, meas_s2_q, meas_s3_q, edge_inc;
    logic [WW-1:0]       win_q;
    logic                win_last;
    logic [23:0]         cnt_q  [NUM_MEAS];
    logic [23:0]         cnt_d  [NUM_MEAS];
    logic [23:0]         freq_q [NUM_MEAS];
    logic                unused_wdata;

    assign ctrl_wr  = reg_select & reg_wr & (reg_addr == 4'd1);
    assign cfg_wr   = reg_select & reg_wr & (reg_addr == 4'd2);
    assign div_last = (div_q == DW'(SCLK_DIV - 1));
    assign bit_last = (bit_q == BW'(CFG_BITS - 1));
    assign win_last = (win_q == WW'(FREQ_WINDOW - 1));
    assign cap_d    = (cap_q << 1) | CFG_BITS'(pll_sdo);
    assign unused_wdata = ^reg_wdata;

    assign pclk_reset_req = pclk_req_q;
    assign pll_nreset     = nreset_q;
    assign pll_bypass     = bypass_q;
    assign led            = led_q;
    assign pll_sclk       = sclk_q;
    assign pll_sdi        = sdi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_req_q  <= 1'b1;
            nreset_q    <= 1'b0;
            bypass_q    <= 1'b0;
            led_q       <= 1'b0;
            locked_s1_q <= 1'b0;
            locked_s2_q <= 1'b0;
        end else begin
            locked_s1_q <= pll_locked;
            locked_s2_q <= locked_s1_q;
            if (ctrl_wr) begin
                pclk_req_q <= reg_wdata[0];
                nreset_q   <= reg_wdata[1];
                bypass_q   <= reg_wdata[6];
                led_q      <= reg_wdata[7];
            end
        end
    end

    // shift_q is pre-shifted on entry to HIGH so its MSB is the next bit to drive
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
            shift_q <= '0;
            cap_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_wr) begin
                        shift_q <= reg_wdata[CFG_BITS-1:0];
                        sdi_q   <= reg_wdata[CFG_BITS-1];
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        bit_q   <= '0;
                        div_q   <= '0;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (div_last) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                        cap_q   <= cap_d;
                        shift_q <= shift_q << 1;
                        state_q <= HIGH;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            sdi_q   <= shift_q[CFG_BITS-1];
                            state_q <= LOW;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned n = 0; n < NUM_MEAS; n++) begin
            edge_inc[n] = meas_s2_q[n] & ~meas_s3_q[n] & (cnt_q[n] != 24'hffffff);
            cnt_d[n]    = cnt_q[n] + {23'b0, edge_inc[n]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meas_s1_q <= '0;
            meas_s2_q <= '0;
            meas_s3_q <= '0;
            win_q     <= '0;
            for (int unsigned n = 0; n < NUM_MEAS; n++) begin
                cnt_q[n]  <= '0;
                freq_q[n] <= '0;
            end
        end else begin
            meas_s1_q <= meas_in;
            meas_s2_q <= meas_s1_q;
            meas_s3_q <= meas_s2_q;
            win_q     <= win_last ? '0 : win_q + WW'(1);
            for (int unsigned n = 0; n < NUM_MEAS; n++) begin
                if (win_last) begin
                    freq_q[n] <= cnt_d[n];
                    cnt_q[n]  <= '0;
                end else begin
                    cnt_q[n] <= cnt_d[n];
                end
            end
        end
    end

    always_comb begin
        reg_rdata = 32'hffffffff;
        case (reg_addr)
            4'd0: reg_rdata = ID_VAL;
            4'd1: reg_rdata = {24'b0, led_q, bypass_q, 3'b0, locked_s2_q, nreset_q, pclk_req_q};
            4'd2: begin
                reg_rdata     = 32'(cap_q);
                reg_rdata[31] = busy_q;
                reg_rdata[30] = done_q;
            end
            4'd3: reg_rdata = '0;
            default: begin
                for (int unsigned n = 0; n < NUM_MEAS; n++) begin
                    if (reg_addr == 4'(4 + n))
                        reg_rdata = {8'h0, freq_q[n]};
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sys_ctrl_regs.sv
// Self-checking bench for sys_ctrl_regs: register map, CTRL, PLL shifter
// (sdo looped to sdi), reset abort and frequency measurement.
module tb_sys_ctrl_regs;

    localparam logic [31:0] ID       = 32'h00800001;
    localparam int unsigned CFG      = 26;
    localparam int unsigned DIV      = 4;
    localparam int unsigned WINDOW   = 1000;

    logic        clk = 1'b0;
    logic        reset, reg_select, reg_wr;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        pll_nreset, pll_bypass, pll_locked, pll_sclk, pll_sdi, pll_sdo;
    logic        pclk_reset_req, led;
    logic [1:0]  meas_in;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];
    logic        bit_q [$];

    assign pll_sdo = pll_sdi;
    always #5 clk = ~clk;

    sys_ctrl_regs #(
        .ID_VAL     (ID),
        .CFG_BITS   (CFG),
        .SCLK_DIV   (DIV),
        .NUM_MEAS   (2),
        .FREQ_WINDOW(WINDOW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .reg_select    (reg_select),
        .reg_wr        (reg_wr),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_rdata     (reg_rdata),
        .pll_nreset    (pll_nreset),
        .pll_bypass    (pll_bypass),
        .pll_locked    (pll_locked),
        .pll_sclk      (pll_sclk),
        .pll_sdi       (pll_sdi),
        .pll_sdo       (pll_sdo),
        .pclk_reset_req(pclk_reset_req),
        .led           (led),
        .meas_in       (meas_in)
    );

    // Drives one write cycle; returns at the following negedge with select low.
    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        reg_select = 1'b1;
        reg_wr     = 1'b1;
        reg_addr   = addr;
        reg_wdata  = data;
        @(negedge clk);
        reg_select = 1'b0;
        reg_wr     = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0]  addr_tab [8];
        logic [31:0] exp;
        reset = 1'b1; reg_select = 1'b0; reg_wr = 1'b0; reg_addr = '0; reg_wdata = '0;
        pll_locked = 1'b0; meas_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if ({pclk_reset_req, pll_nreset, pll_bypass, led, pll_sclk, pll_sdi} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b expected %b",
                     {pclk_reset_req, pll_nreset, pll_bypass, led, pll_sclk, pll_sdi}, 6'b100000);
        end
        addr_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
        exp_q.push_back(ID);
        exp_q.push_back(32'h00000001);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'hffffffff);
        exp_q.push_back(32'hffffffff);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reg_addr = addr_tab[i];
            #1;
            exp = exp_q.pop_front();
            vectors++;
            if (reg_rdata !== exp) begin
                miscompares++;
                $display("FAIL reset_read addr %0d got %h expected %h", addr_tab[i], reg_rdata, exp);
            end
        end
    endtask

    task automatic test_ctrl();
        logic found;
        logic [31:0] exp;
        bus_write(4'd1, 32'h000000c2);
        #1;
        vectors++;
        if ({pll_nreset, pll_bypass, led, pclk_reset_req} !== 4'b1110) begin
            miscompares++;
            $display("FAIL ctrl_outputs got %b expected %b",
                     {pll_nreset, pll_bypass, led, pclk_reset_req}, 4'b1110);
        end
        exp_q.push_back(32'h000000c2);
        exp = exp_q.pop_front();
        vectors++;
        if (reg_rdata !== exp) begin
            miscompares++;
            $display("FAIL ctrl_read got %h expected %h", reg_rdata, exp);
        end
        @(negedge clk);
        pll_locked = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (reg_rdata[2] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL ctrl_locked got %b expected 1 within 3 cycles", reg_rdata[2]);
        end
        bus_write(4'd1, 32'hffffffff);
        reg_addr = 4'd1;
        #1;
        exp_q.push_back(32'h000000c7);
        exp = exp_q.pop_front();
        vectors++;
        if (reg_rdata !== exp) begin
            miscompares++;
            $display("FAIL ctrl_allones got %h expected %h", reg_rdata, exp);
        end
        bus_write(4'd1, 32'h000000c2);
    endtask

    task automatic test_pll_transfer(input logic [31:0] data, input logic inject,
                                     input logic [31:0] inj_data);
        int   busy_cnt, pulses;
        logic prev_sclk, busy, finished, exp_bit;
        logic [31:0] exp;
        for (int i = CFG - 1; i >= 0; i--) bit_q.push_back(data[i]);
        bus_write(4'd2, data);
        busy_cnt = 0; pulses = 0; prev_sclk = 1'b0; finished = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #1;
            busy = reg_rdata[31];
            if (c == 0) begin
                vectors++;
                if (reg_rdata[31:30] !== 2'b10) begin
                    miscompares++;
                    $display("FAIL pll_start_flags got %b expected %b", reg_rdata[31:30], 2'b10);
                end
            end
            if (busy) busy_cnt++;
            if (pll_sclk && !prev_sclk) begin
                pulses++;
                vectors++;
                if (bit_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pll_extra_pulse got pulse %0d expected none", pulses);
                end else begin
                    exp_bit = bit_q.pop_front();
                    if (pll_sdi !== exp_bit) begin
                        miscompares++;
                        $display("FAIL pll_sdi bit %0d got %b expected %b", pulses, pll_sdi, exp_bit);
                    end
                end
            end
            prev_sclk = pll_sclk;
            if (!busy && busy_cnt > 0) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
            reg_select = inject && (c == 50);
            reg_wr     = inject && (c == 50);
            if (inject && c == 50) reg_wdata = inj_data;
        end
        reg_select = 1'b0;
        reg_wr     = 1'b0;
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL pll_timeout got busy after 400 cycles expected idle");
        end
        vectors++;
        if (busy_cnt != 2 * DIV * CFG) begin
            miscompares++;
            $display("FAIL pll_busy_cycles got %0d expected %0d", busy_cnt, 2 * DIV * CFG);
        end
        vectors++;
        if (pulses != CFG || bit_q.size() != 0) begin
            miscompares++;
            $display("FAIL pll_pulses got %0d expected %0d", pulses, CFG);
            bit_q.delete();
        end
        exp_q.push_back(32'h40000000 | (data & 32'h03ffffff));
        exp = exp_q.pop_front();
        vectors++;
        if (reg_rdata !== exp) begin
            miscompares++;
            $display("FAIL pll_readback got %h expected %h", reg_rdata, exp);
        end
        vectors++;
        if ({pll_sclk, pll_sdi} !== {1'b0, data[0]}) begin
            miscompares++;
            $display("FAIL pll_idle_lines got %b expected %b", {pll_sclk, pll_sdi}, {1'b0, data[0]});
        end
    endtask

    task automatic test_reset_abort();
        int   pulses;
        logic prev_sclk, reached;
        bus_write(4'd2, 32'h0155aa33);
        pulses = 0; prev_sclk = 1'b0; reached = 1'b0;
        for (int c = 0; c < 400; c++) begin
            #1;
            if (pll_sclk && !prev_sclk) pulses++;
            prev_sclk = pll_sclk;
            if (pulses == 11) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL abort_reach got %0d pulses expected 11", pulses);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if ({pll_sclk, pll_sdi, reg_rdata[31:30]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_state got %b expected %b", {pll_sclk, pll_sdi, reg_rdata[31:30]}, 4'b0000);
        end
        reset = 1'b0;
        pulses = 0; prev_sclk = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            #1;
            if (pll_sclk && !prev_sclk) pulses++;
            prev_sclk = pll_sclk;
        end
        vectors++;
        if (pulses != 0 || reg_rdata[31] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet got %0d pulses busy %b expected 0 pulses busy 0", pulses, reg_rdata[31]);
        end
    endtask

    task automatic test_freq();
        logic [31:0] exp;
        @(negedge clk);
        reset = 1'b1; meas_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        reg_addr = 4'd4;
        for (int c = 0; c < 2600; c++) begin
            @(negedge clk);
            if (c % 5 == 0) meas_in[0] = ~meas_in[0];
            reg_select = (c == 300) || (c == 700);
            reg_wr     = (c == 300) || (c == 700);
            if (c == 300) begin reg_addr = 4'd1; reg_wdata = 32'h000000c2; end
            else if (c == 700) begin reg_addr = 4'd2; reg_wdata = 32'h02aaaaaa; end
            else reg_addr = 4'd4;
            if (c == 500) begin
                exp_q.push_back(32'd0);
                #1;
                exp = exp_q.pop_front();
                vectors++;
                if (reg_rdata !== exp) begin
                    miscompares++;
                    $display("FAIL freq_first_window got %h expected %h", reg_rdata, exp);
                end
            end
        end
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd0);
        @(negedge clk);
        reg_select = 1'b0; reg_wr = 1'b0;
        reg_addr = 4'd4;
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if (reg_rdata < exp - 1 || reg_rdata > exp + 1 || $isunknown(reg_rdata)) begin
            miscompares++;
            $display("FAIL freq0 got %0d expected %0d +-1", reg_rdata, exp);
        end
        @(negedge clk);
        reg_addr = 4'd5;
        #1;
        exp = exp_q.pop_front();
        vectors++;
        if (reg_rdata !== exp) begin
            miscompares++;
            $display("FAIL freq1 got %h expected %h", reg_rdata, exp);
        end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_pll_transfer(32'h02aaaaaa, 1'b0, 32'h0);
        test_pll_transfer(32'h01555555, 1'b1, 32'h02aaaaaa);
        test_reset_abort();
        test_freq();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
